cpu_control: RTL

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_decode.sv | 52 +++++
 rtl/cpu_control.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcodes, FSM states and the
// alu_op encoding consumed by the datapath ALU.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_FETCH2 = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU ops for ADD..OR equal opcode[2:0], so the decoder can pass them through.
  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  function automatic logic is_two_byte(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational strobe decode from the current FSM state and instruction register.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  input  state_t     state,
  output logic [1:0] rd_a,
  output logic [1:0] rd_b,
  output logic [1:0] reg_waddr,
  output logic       reg_we,
  output logic       flag_we,
  output logic       wdata_sel,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       halted
);

  logic [3:0] op;
  logic       exec;

  assign op        = ir[7:4];
  assign exec      = (state == S_EXEC);
  assign rd_a      = ir[3:2];
  assign rd_b      = ir[1:0];
  assign reg_waddr = ir[3:2];
  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign halted    = (state == S_HALT);

  always_comb begin
    reg_we    = 1'b0;
    flag_we   = 1'b0;
    wdata_sel = 1'b0;
    alu_op    = ALU_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        alu_op  = op[2:0];
        reg_we  = exec;
        flag_we = exec;
      end
      OP_MOV: begin
        alu_op = ALU_PASS;
        reg_we = exec;
      end
      OP_LDI: begin
        wdata_sel = 1'b1;
        reg_we    = exec;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control FSM for a 4-bit-PC toy CPU; holds state, pc, ir and imm.
// Optional single-step mode: define CPU_CONTROL_STEP_EN to add the step input.
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef CPU_CONTROL_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] instr,
  input  logic       zero,
  output logic [3:0] imem_addr,
  output logic [1:0] rd_a,
  output logic [1:0] rd_b,
  output logic       reg_we,
  output logic [1:0] reg_waddr,
  output logic       wdata_sel,
  output logic [3:0] imm,
  output logic [2:0] alu_op,
  output logic       flag_we,
  output logic       busy,
  output logic       halted
);

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] imm_q, imm_d;
  logic       fetch_go;
  logic       dec_reg_we, dec_flag_we;

`ifdef CPU_CONTROL_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      imm_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: if (fetch_go) begin
        ir_d    = instr;
        pc_d    = pc_q + 4'd1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = is_two_byte(ir_q[7:4]) ? S_FETCH2 : S_EXEC;
      S_FETCH2: begin
        imm_d   = instr[3:0];
        pc_d    = pc_q + 4'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ir_q[7:4] == OP_JMP) pc_d = imm_q;
        if (ir_q[7:4] == OP_JZ && zero) pc_d = imm_q;
        state_d = (ir_q[7:4] == OP_HLT) ? S_HALT : S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  cpu_decode u_dec (
    .ir        (ir_q),
    .state     (state_q),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .reg_waddr (reg_waddr),
    .reg_we    (dec_reg_we),
    .flag_we   (dec_flag_we),
    .wdata_sel (wdata_sel),
    .alu_op    (alu_op),
    .busy      (busy),
    .halted    (halted)
  );

  // A reset landing on EXEC must cancel that cycle's write, not just the next.
  assign reg_we    = dec_reg_we & ~rst;
  assign flag_we   = dec_flag_we & ~rst;
  assign imem_addr = pc_q;
  assign imm       = imm_q;

endmodule
